// File: rtl/stream_pkg.sv
// rtl/stream_pkg.sv - shared constants and state type for the stream frame arbiter
package stream_pkg;

  localparam int DEFAULT_DATA_WIDTH = 30;

  typedef enum logic {
    WAIT_SOP = 1'b0,
    STREAM   = 1'b1
  } arb_state_t;

endpackage

// File: rtl/stream_out_reg.sv
// rtl/stream_out_reg.sv - single-entry output register with downstream back-pressure
module stream_out_reg
  import stream_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clock_clk,
  input  logic                  reset_n,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  load_sop,
  input  logic                  load_eop,
  input  logic                  ready_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  sop_out,
  output logic                  eop_out,
  output logic                  valid_out,
  output logic                  can_load
);

  // The slot is free when empty or when its current beat leaves this cycle.
  assign can_load = ready_in || !valid_out;

  always_ff @(posedge clock_clk) begin
    if (!reset_n) begin
      data_out  <= '0;
      sop_out   <= 1'b0;
      eop_out   <= 1'b0;
      valid_out <= 1'b0;
    end else if (load) begin
      data_out  <= load_data;
      sop_out   <= load_sop;
      eop_out   <= load_eop;
      valid_out <= 1'b1;
    end else if (ready_in) begin
      sop_out   <= 1'b0;
      eop_out   <= 1'b0;
      valid_out <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_frame_arbiter.sv
// rtl/stream_frame_arbiter.sv - two-source frame arbiter that only switches sources between frames
module stream_frame_arbiter
  import stream_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clock_clk,
  input  logic                   reset_n,
  input  logic                   sel_in,
  input  logic [DATA_WIDTH-1:0]  src0_data,
  input  logic [DATA_WIDTH-1:0]  src1_data,
  input  logic                   src0_sop,
  input  logic                   src1_sop,
  input  logic                   src0_eop,
  input  logic                   src1_eop,
  input  logic                   src0_valid,
  input  logic                   src1_valid,
  output logic                   src0_ready,
  output logic                   src1_ready,
  output logic [DATA_WIDTH-1:0]  data_out,
  output logic                   sop_out,
  output logic                   eop_out,
  output logic                   valid_out,
  input  logic                   ready_in,
  output logic                   active_src,
  output logic                   switch_pending,
  output logic [COUNT_WIDTH-1:0] frame_count
);

  arb_state_t            state, state_nxt;
  logic                  src_q;
  logic                  fresh;
  logic [DATA_WIDTH-1:0] act_data;
  logic                  act_valid, act_sop, act_eop;
  logic                  can_load, accept, forward, frame_end;

  // The first cycle out of reset is a WAIT_SOP entry, so the selection is taken live from sel_in.
  assign active_src     = (fresh && reset_n) ? sel_in : src_q;
  assign switch_pending = sel_in != active_src;

  assign act_data  = active_src ? src1_data  : src0_data;
  assign act_valid = active_src ? src1_valid : src0_valid;
  assign act_sop   = active_src ? src1_sop   : src0_sop;
  assign act_eop   = active_src ? src1_eop   : src0_eop;

  // The idle camera is always drained so it never stalls.
  assign src0_ready = reset_n && (active_src ? 1'b1 : can_load);
  assign src1_ready = reset_n && (active_src ? can_load : 1'b1);

  assign accept    = reset_n && act_valid && can_load;
  assign forward   = accept && ((state == STREAM) || act_sop);
  assign frame_end = forward && act_eop;

  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_SOP: if (forward && !act_eop) state_nxt = STREAM;
      STREAM:   if (frame_end)           state_nxt = WAIT_SOP;
    endcase
  end

  always_ff @(posedge clock_clk) begin
    if (!reset_n) begin
      state       <= WAIT_SOP;
      src_q       <= 1'b0;
      fresh       <= 1'b1;
      frame_count <= '0;
    end else begin
      state <= state_nxt;
      fresh <= 1'b0;
      if (fresh || frame_end) src_q <= sel_in;
      if (frame_end) frame_count <= frame_count + 1'b1;
    end
  end

  stream_out_reg #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_out_reg (
    .clock_clk(clock_clk),
    .reset_n  (reset_n),
    .load     (forward),
    .load_data(act_data),
    .load_sop (act_sop),
    .load_eop (act_eop),
    .ready_in (ready_in),
    .data_out (data_out),
    .sop_out  (sop_out),
    .eop_out  (eop_out),
    .valid_out(valid_out),
    .can_load (can_load)
  );

endmodule

// File: tb/tb_stream_frame_arbiter.sv
// tb/tb_stream_frame_arbiter.sv - directed and randomized bench for stream_frame_arbiter
module tb_stream_frame_arbiter;

  localparam int DW = 30;
  localparam int CW = 4;

  logic          clock_clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          sel_in = 1'b0;
  logic [DW-1:0] src0_data = '0, src1_data = '0;
  logic          src0_sop = 1'b0, src1_sop = 1'b0, src0_eop = 1'b0, src1_eop = 1'b0;
  logic          src0_valid = 1'b0, src1_valid = 1'b0;
  logic          src0_ready, src1_ready;
  logic [DW-1:0] data_out;
  logic          sop_out, eop_out, valid_out;
  logic          ready_in = 1'b1;
  logic          active_src, switch_pending;
  logic [CW-1:0] frame_count;

  always #5 clock_clk = ~clock_clk;

  stream_frame_arbiter #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
    .clock_clk(clock_clk), .reset_n(reset_n), .sel_in(sel_in),
    .src0_data(src0_data), .src1_data(src1_data),
    .src0_sop(src0_sop), .src1_sop(src1_sop),
    .src0_eop(src0_eop), .src1_eop(src1_eop),
    .src0_valid(src0_valid), .src1_valid(src1_valid),
    .src0_ready(src0_ready), .src1_ready(src1_ready),
    .data_out(data_out), .sop_out(sop_out), .eop_out(eop_out), .valid_out(valid_out),
    .ready_in(ready_in), .active_src(active_src), .switch_pending(switch_pending),
    .frame_count(frame_count)
  );

  int checks = 0;
  int errors = 0;

  // Reference: which camera owns the link, whether a frame is open, and the one-beat output slot.
  bit            m_fresh, m_open, m_full, m_act;
  int            m_count;
  logic [DW-1:0] m_data;
  bit            m_sop, m_eop;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_fresh = 1; m_open = 0; m_full = 0; m_act = 0; m_count = 0;
  endtask

  task automatic drive(input bit src, input bit v, input bit s, input bit e, input logic [DW-1:0] d);
    if (src) begin
      src1_valid = v; src1_sop = s; src1_eop = e; src1_data = d;
    end else begin
      src0_valid = v; src0_sop = s; src0_eop = e; src0_data = d;
    end
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, '0);
    drive(1, 0, 0, 0, '0);
  endtask

  // One clock: check everything against the reference, then advance the reference.
  task automatic cycle();
    bit eff, slot, av, as, ae, acc, fwd;
    logic [DW-1:0] ad;
    #1;
    eff  = (m_fresh && reset_n) ? sel_in : m_act;
    slot = ready_in || !m_full;
    chk("active_src", active_src, eff);
    chk("switch_pending", switch_pending, sel_in != eff);
    chk("src0_ready", src0_ready, reset_n && (eff ? 1'b1 : slot));
    chk("src1_ready", src1_ready, reset_n && (eff ? slot : 1'b1));
    chk("valid_out", valid_out, m_full);
    chk("frame_count", frame_count, m_count);
    if (m_full) begin
      chk("data_out", data_out, m_data);
      chk("sop_out", sop_out, m_sop);
      chk("eop_out", eop_out, m_eop);
    end
    av = eff ? src1_valid : src0_valid;
    as = eff ? src1_sop : src0_sop;
    ae = eff ? src1_eop : src0_eop;
    ad = eff ? src1_data : src0_data;
    acc = reset_n && av && slot;
    fwd = acc && (m_open || as);
    @(posedge clock_clk);
    if (!reset_n) begin
      model_reset();
    end else begin
      if (fwd) begin
        m_full = 1; m_data = ad; m_sop = as; m_eop = ae;
        m_open = !ae;
      end else if (ready_in) begin
        m_full = 0;
      end
      if (fwd && ae) begin
        m_count = (m_count + 1) % (1 << CW);
        m_act = sel_in;
      end
      if (m_fresh) m_act = sel_in;
      m_fresh = 0;
    end
    @(negedge clock_clk);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clock_clk);
    @(negedge clock_clk);
    cycle();
    chk("rst_data", data_out, 0);
    chk("rst_sop", sop_out, 0);
    chk("rst_eop", eop_out, 0);
    chk("rst_ready0", src0_ready, 0);
    chk("rst_ready1", src1_ready, 0);
    reset_n = 1;

    // Basic 4-beat forward on src0
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, i == 0, i == 3, DW'(i + 1));
      cycle();
      chk("fwd_data", data_out, i + 1);
      chk("fwd_sop", sop_out, i == 0);
      chk("fwd_eop", eop_out, i == 3);
    end
    idle();
    chk("fwd_count", frame_count, 1);
    cycle();

    // Switch request during src0 beat 2 takes effect only after eop
    for (int i = 0; i < 4; i++) begin
      if (i == 2) sel_in = 1;
      drive(0, 1, i == 0, i == 3, DW'('h10 + i));
      cycle();
      if (i == 2) chk("sw_pending", switch_pending, 1);
    end
    idle();
    chk("sw_active", active_src, 1);
    chk("sw_pending_clr", switch_pending, 0);
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, i == 0, i == 2, DW'('h100 + i));
      cycle();
      chk("sw_src1_data", data_out, 'h100 + i);
    end
    idle();
    cycle();

    // Align to sop: leading non-sop beats are dropped
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, i == 1, DW'('h200 + i));
      cycle();
      chk("align_ready", src1_ready, 1);
      chk("align_drop", valid_out, 0);
    end
    drive(1, 1, 1, 0, DW'('h2aa));
    cycle();
    chk("align_first", data_out, 'h2aa);
    chk("align_sop", sop_out, 1);
    drive(1, 1, 0, 1, DW'('h2ab));
    cycle();
    idle();
    cycle();

    // Back-pressure for 5 cycles mid-frame
    drive(1, 1, 1, 0, DW'('h300)); cycle();
    drive(1, 1, 0, 0, DW'('h301)); cycle();
    ready_in = 0;
    drive(1, 1, 0, 0, DW'('h302));
    repeat (5) begin
      cycle();
      chk("bp_data", data_out, 'h301);
      chk("bp_valid", valid_out, 1);
      chk("bp_rdy_act", src1_ready, 0);
      chk("bp_rdy_idle", src0_ready, 1);
    end
    ready_in = 1;
    cycle();
    chk("bp_next", data_out, 'h302);
    drive(1, 1, 0, 1, DW'('h303)); cycle();
    chk("bp_last", data_out, 'h303);
    idle();
    cycle();

    // Single-beat frames up to all-ones, then one more wraps the counter
    for (int k = 0; k < 40 && m_count != (1 << CW) - 1; k++) begin
      drive(1, 1, 1, 1, DW'('h400 + k)); cycle();
    end
    chk("wrap_pre", frame_count, (1 << CW) - 1);
    drive(1, 1, 1, 1, DW'('h4ff)); cycle();
    chk("wrap_count", frame_count, 0);
    chk("wrap_data", data_out, 'h4ff);
    chk("wrap_sopeop", {sop_out, eop_out}, 2'b11);
    drive(1, 1, 0, 0, DW'('h4fe)); cycle();
    chk("wrap_wait", valid_out, 0);
    idle();
    sel_in = 0;
    cycle();

    // Reset on beat 2 of a src0 frame
    cycle();
    for (int i = 0; i < 3; i++) begin
      if (i == 2) reset_n = 0;
      drive(0, 1, i == 0, 0, DW'('h500 + i));
      cycle();
    end
    chk("rr_valid", valid_out, 0);
    chk("rr_data", data_out, 0);
    chk("rr_sopeop", {sop_out, eop_out}, 2'b00);
    chk("rr_count", frame_count, 0);
    chk("rr_active", active_src, 0);
    chk("rr_ready", {src0_ready, src1_ready}, 2'b00);
    reset_n = 1;
    for (int i = 3; i < 5; i++) begin
      drive(0, 1, 0, i == 4, DW'('h500 + i));
      cycle();
      chk("rr_ignore", valid_out, 0);
    end
    drive(0, 1, 1, 0, DW'('h5aa)); cycle();
    chk("rr_resume", data_out, 'h5aa);
    chk("rr_count0", frame_count, 0);

    // Randomized traffic against the reference
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(15) == 0) sel_in = ~sel_in;
      ready_in = ($urandom_range(3) != 0);
      reset_n  = ($urandom_range(499) != 0);
      drive(0, $urandom_range(1), $urandom_range(3) == 0, $urandom_range(3) == 0, DW'($urandom));
      drive(1, $urandom_range(1), $urandom_range(3) == 0, $urandom_range(3) == 0, DW'($urandom));
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stream_frame_arbiter.md
STREAM_FRAME_ARBITER -- requirements
Module: stream_frame_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 30, meaning pixel beat width in bits (the expanded 30-bit RGB).
REQ-002 SHALL have parameter COUNT_WIDTH, default 16, meaning width of the completed-frame counter.
REQ-003 SHALL have one clock and a synchronous, active-low reset; clock port clock_clk, reset port reset_n.
REQ-004 SHALL have ports, in order:
- clock_clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- sel_in  in  1  requested source (0 = src0, 1 = src1)
- src0_data / src1_data  in  DATA_WIDTH  source pixel data
- src0_sop / src1_sop  in  1  start of frame
- src0_eop / src1_eop  in  1  end of frame
- src0_valid / src1_valid  in  1  source beat valid
- src0_ready / src1_ready  out  1  source beat accepted
- data_out  out  DATA_WIDTH  forwarded pixel
- sop_out, eop_out, valid_out  out  1  forwarded framing and valid
- ready_in  in  1  downstream ready
- active_src  out  1  source currently locked
- switch_pending  out  1  sel_in differs from active_src, switch not yet applied
- frame_count  out  COUNT_WIDTH  frames forwarded

Function
REQ-005 SHALL accept a source beat in a cycle where srcN_valid && srcN_ready.
REQ-006 SHALL implement states WAIT_SOP and STREAM.
REQ-007 On entry to WAIT_SOP, including the first cycle after reset, SHALL load active_src from sel_in; active_src SHALL NOT change in any other cycle.
REQ-008 In WAIT_SOP:
- accepted non-sop beats from the active source SHALL be discarded;
- an accepted sop beat from the active source SHALL be forwarded;
- the state SHALL move to STREAM unless that beat also has eop.
REQ-009 In STREAM:
- every accepted active-source beat SHALL be forwarded;
- an accepted eop beat SHALL move the state to WAIT_SOP.
REQ-010 A sop seen in STREAM (missing eop) SHALL be forwarded as-is; the state SHALL be unchanged.
REQ-011 The inactive source's ready SHALL be 1 in every cycle while reset_n is high. All its beats SHALL be discarded so the camera never stalls.
REQ-012 The active source's ready SHALL be ready_in || !valid_out (single output register).
REQ-013 Forwarded beats SHALL appear on data_out, sop_out, eop_out and valid_out exactly one cycle after acceptance.
REQ-014 The output register SHALL hold its contents while valid_out && !ready_in.
REQ-015 valid_out SHALL clear when ready_in is high and no new beat is loaded.
REQ-016 frame_count SHALL increment by 1 on each accepted, forwarded eop beat, including a single-beat sop&&eop frame.
REQ-017 frame_count SHALL wrap from all-ones to 0.
REQ-018 switch_pending SHALL be combinational (sel_in != active_src).
REQ-019 If sel_in toggles mid-frame and returns before eop, no switch SHALL occur.

Reset
REQ-020 While reset_n is low:
- valid_out, sop_out and eop_out SHALL be 0;
- data_out SHALL be 0;
- state SHALL be WAIT_SOP;
- active_src SHALL be 0 and frame_count SHALL be 0;
- both ready outputs SHALL be 0.
REQ-021 Reset asserted mid-frame SHALL abandon the frame without incrementing frame_count. After release, output SHALL resume only at the next active-source sop.

Structure
REQ-022 Package stream_pkg SHALL hold the DATA_WIDTH default constant and the arbiter state enum type (WAIT_SOP, STREAM).
REQ-023 The output register SHALL be a sub-module, stream_out_reg, holding data/sop/eop/valid with ready_in back-pressure.
REQ-024 State, active_src and frame_count SHALL remain in stream_frame_arbiter.

Verification
REQ-025 Basic forward: sel_in=0; src0 sends a 4-beat frame (sop on beat 0, eop on beat 3, data 1..4) with ready_in=1. Required: data_out 1..4 one cycle later, sop/eop aligned, frame_count=1.
REQ-026 Mid-frame switch: sel_in goes 0->1 during src0 beat 2. Required:
- switch_pending=1 until the cycle after src0 eop;
- then active_src=1;
- the following src1 frame is forwarded intact.
REQ-027 Align to sop: with the state in WAIT_SOP, src1 presents 3 non-sop beats then sop. Required: the 3 beats are discarded with src1_ready=1; the first beat on the output is the sop beat.
REQ-028 Back-pressure: ready_in=0 for 5 cycles mid-frame. Required: data_out is stable and valid_out stays 1; the active ready=0 and the inactive ready=1; no beat is lost or duplicated.
REQ-029 Single-beat frame and wrap: preload frame_count to all-ones, then send a sop&&eop beat. Required: the beat is forwarded, frame_count=0, and the state remains WAIT_SOP.
REQ-030 Reset mid-frame: drive reset_n low on beat 2. Required:
- next cycle all outputs are 0;
- after release, beats are ignored until the next sop;
- frame_count=0.
